// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned WAIT_CNT_W      = 8;
  localparam int unsigned STALL_CNT_W     = 16;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned WB_W            = 2;
  localparam int unsigned WB_REGWRITE_BIT = 0;
  localparam int unsigned WB_MEMTOREG_BIT = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  // Load enables and squash controls presented to the pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
  } hazard_ctrl_t;

  // Free-flowing pipeline: every stage advances, nothing squashed.
  function automatic hazard_ctrl_t ctrl_pass();
    hazard_ctrl_t c;
    c              = '0;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.id_ex_write  = 1'b1;
    c.ex_mem_write = 1'b1;
    return c;
  endfunction

  // Whole pipeline held while memory is outstanding; WB of MEM_WB squashed.
  function automatic hazard_ctrl_t ctrl_freeze();
    hazard_ctrl_t c;
    c               = '0;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

  // WB field as loaded into MEM_WB, with RegWrite/MemtoReg killed on bubble.
  function automatic logic [WB_W-1:0] wb_apply_bubble(logic [WB_W-1:0] wb, logic bubble);
    logic [WB_W-1:0] r;
    r = wb;
    if (bubble) begin
      r[WB_REGWRITE_BIT] = 1'b0;
      r[WB_MEMTOREG_BIT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the load in EX and the sources in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_memread,
  output logic                  hazard
);

  // R0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// with timeout to a sticky FAULT state, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic                   ex_memread,
  input  logic                   branch_taken,
  input  logic                   mem_access,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   ex_mem_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   mem_wb_bubble,
  output logic [STATE_W-1:0]     state,
  output logic                   fault,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [WAIT_CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_q, stall_d;
  logic                     fault_q, fault_d;
  logic                     hazard;
  hazard_ctrl_t             flow_ctrl;
  hazard_ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_rt      (ex_rt),
    .ex_memread (ex_memread),
    .hazard     (hazard)
  );

  // Response with memory satisfied: branch wins over load-use (ID is wrong-path).
  always_comb begin
    flow_ctrl = ctrl_pass();
    if (branch_taken) begin
      flow_ctrl.if_id_flush  = 1'b1;
      flow_ctrl.id_ex_bubble = 1'b1;
    end else if (hazard) begin
      flow_ctrl.pc_write     = 1'b0;
      flow_ctrl.if_id_write  = 1'b0;
      flow_ctrl.id_ex_bubble = 1'b1;
    end
  end

  // Next state, wait counter, fault and stall counter plus Mealy controls.
  always_comb begin
    ctrl       = flow_ctrl;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = stall_q;

    case (state_q)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          ctrl       = ctrl_freeze();
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl = ctrl_freeze();
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_FAULT: begin
        ctrl = ctrl_freeze();
      end
      default: begin
        ctrl    = ctrl_freeze();
        state_d = ST_RUN;
      end
    endcase

    fault_d = fault_q | (state_d == ST_FAULT);

    if (!ctrl.pc_write && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State and counters; reset returns to RUN immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      fault_q    <= fault_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign id_ex_write   = ctrl.id_ex_write;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign state         = state_q;
  assign fault         = fault_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a per-cycle reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_memread = 1'b0, branch_taken = 1'b0, mem_access = 1'b0, mem_ready = 1'b0;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_bubble, mem_wb_bubble;
  logic [1:0]  state;
  logic        fault;
  logic [15:0] stall_cycles;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_rt         (ex_rt),
    .ex_memread    (ex_memread),
    .branch_taken  (branch_taken),
    .mem_access    (mem_access),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .mem_wb_bubble (mem_wb_bubble),
    .state         (state),
    .fault         (fault),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctrl;   // pc, if_id, id_ex, ex_mem, flush, bubble, mem_wb_bubble
    logic [1:0]  st;
    logic        flt;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: 0 = RUN, 1 = MEM_WAIT, 2 = FAULT.
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_fault = 1'b0;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // One cycle: drive inputs after the edge, push the model's expectation, advance the model.
  task automatic step(input bit rst, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] xrt,
                      input bit mr, input bit br, input bit ma, input bit rdy);
    bit         hz, frz;
    logic [6:0] c;
    exp_t       e;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs = rs; id_rt = rt; ex_rt = xrt;
    ex_memread = mr; branch_taken = br; mem_access = ma; mem_ready = rdy;
    if (!rst) begin
      m_state = 0; m_wait = 0; m_stall = 0; m_fault = 1'b0;
    end
    hz  = mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
    frz = (m_state == 2) || (m_state == 1 && !rdy) || (m_state == 0 && ma && !rdy);
    if (frz)     c = 7'b0000001;
    else if (br) c = 7'b1111110;
    else if (hz) c = 7'b0011010;
    else         c = 7'b1111000;
    e.ctrl  = c;
    e.st    = 2'(m_state);
    e.flt   = m_fault;
    e.stall = 16'(m_stall);
    exp_q.push_back(e);
    if (rst) begin
      if (!c[6] && m_stall < 65535) m_stall++;
      if (m_state == 0) begin
        if (ma && !rdy) begin m_state = 1; m_wait = 0; end
      end else if (m_state == 1) begin
        if (rdy) begin
          m_state = 0; m_wait = 0;
        end else if (m_wait + 1 == int'(TIMEOUT)) begin
          m_state = 2; m_fault = 1'b1;
        end else begin
          m_wait++;
        end
      end
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output set, compare to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ctrl", {pc_write, if_id_write, id_ex_write, ex_mem_write,
                     if_id_flush, id_ex_bubble, mem_wb_bubble}, e.ctrl);
        chk("state", state, e.st);
        chk("fault", fault, e.flt);
        chk("stall_cycles", stall_cycles, e.stall);
      end
    end
  end

  initial begin
    // Reset state
    idle(1'b0); idle(1'b0); idle(1'b1);
    sample();
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_fault", fault, 0);

    // Load to R0 never stalls
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    chk("r0_pc_write", pc_write, 1);
    chk("r0_if_id_write", if_id_write, 1);
    chk("r0_id_ex_bubble", id_ex_bubble, 0);

    // Load-use stall for one cycle
    step(1'b1, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_id_ex_bubble", id_ex_bubble, 1);
    idle(1'b1);
    sample();
    chk("lu_stall_cycles", stall_cycles, 1);
    chk("lu_pc_write_after", pc_write, 1);

    // Branch together with hazard: branch response only
    step(1'b1, 5'd5, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    sample();
    chk("br_flush", if_id_flush, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_write", pc_write, 1);
    idle(1'b1);
    sample();
    chk("br_stall_unchanged", stall_cycles, 1);

    // Memory wait of three low cycles, branch held and acted on at release
    idle(1'b0); idle(1'b1);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk("mw_req_writes", {pc_write, if_id_write, id_ex_write, ex_mem_write}, 0);
    chk("mw_req_mwb", mem_wb_bubble, 1);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk("mw_state1", state, 1);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk("mw_state2", state, 1);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    chk("mw_release_state", state, 1);
    chk("mw_release_flush", if_id_flush, 1);
    chk("mw_release_pc", pc_write, 1);
    idle(1'b1);
    sample();
    chk("mw_run", state, 0);
    chk("mw_stall_cycles", stall_cycles, 3);

    // Timeout into FAULT, then reset clears it
    idle(1'b0); idle(1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      sample();
      if (i == 4) chk("to_state_before", state, 1);
    end
    chk("to_state_fault", state, 2);
    chk("to_fault", fault, 1);
    idle(1'b0);
    sample();
    chk("to_rst_state", state, 0);
    chk("to_rst_fault", fault, 0);
    chk("to_rst_stall", stall_cycles, 0);
    chk("to_rst_pc", pc_write, 1);
    step(1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk("to_rst_hold_stall", stall_cycles, 0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = !(($urandom_range(0, 299) == 0) || (m_state == 2 && $urandom_range(0, 9) == 0));
      step(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    // Saturation of the stall counter
    idle(1'b0); idle(1'b1);
    for (int i = 0; i < 70000; i++) begin
      step(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    idle(1'b1);
    sample();
    chk("sat_stall_cycles", stall_cycles, 16'hFFFF);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
